mem_port_arbiter: RTL and testbench

Arbitrates the core's single memory port between the instruction-fetch requester and the load/store requester. Each data access is configured from its `DataAccess` size and low address bits: byte-lane mask, write-data replication and misalignment check. The block sits between the pipeline's fetch/LSU stages and the external memory interface, and sequences one memory transaction at a time through a small state machine.

---
 rtl/CoreDefs.sv | 23 ++
 rtl/mem_lane_gen.sv | 37 +++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/CoreDefs.sv
// Shared core types: data access sizes, byte masks, address types and the
// memory-port arbiter state encoding.
package CoreDefs;

  typedef enum logic [1:0] {
    ACC_BYTE  = 2'd0,
    ACC_HALF  = 2'd1,
    ACC_WORD  = 2'd2,
    ACC_DWORD = 2'd3
  } DataAccess;

  typedef logic [3:0]  ByteMask;
  typedef logic [31:0] DataAddr;
  typedef logic [31:0] InstAddr;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2,
    ERR  = 2'd3
  } MemArbState;

endpackage

// File: rtl/mem_lane_gen.sv
// Combinational lane configuration for a data access: byte-lane mask,
// lane-replicated write data and misalignment flag on a 32-bit bus.
module mem_lane_gen
  import CoreDefs::*;
(
  input  DataAccess   access,
  input  logic [1:0]  addrLo,
  input  logic [31:0] wdata,
  output ByteMask     byteMask,
  output logic [31:0] wdataRep,
  output logic        misaligned
);

  always_comb begin
    byteMask   = '0;
    wdataRep   = wdata;
    misaligned = 1'b0;
    case (access)
      ACC_BYTE: begin
        byteMask = 4'b0001 << addrLo;
        wdataRep = {4{wdata[7:0]}};
      end
      ACC_HALF: begin
        byteMask   = 4'b0011 << addrLo;
        wdataRep   = {2{wdata[15:0]}};
        misaligned = addrLo[0];
      end
      ACC_WORD: begin
        byteMask   = 4'b1111;
        misaligned = (addrLo != 2'b00);
      end
      // A doubleword can never be served on a 32-bit port.
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and the LSU, one
// transaction at a time. Define MEM_ARB_FAIRNESS_EN to bound data bursts.
module mem_port_arbiter
  import CoreDefs::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int PC_WIDTH       = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_inst_req,
  input  logic [PC_WIDTH-1:0]   i_inst_addr,
  output logic                  o_inst_ack,
  output logic [31:0]           o_inst_data,
  input  logic                  i_data_req,
  input  logic                  i_data_we,
  input  logic [ADDR_WIDTH-1:0] i_data_addr,
  input  DataAccess             i_data_access,
  input  logic [DATA_WIDTH-1:0] i_data_wdata,
  output logic                  o_data_ack,
  output logic                  o_data_err,
  output logic [DATA_WIDTH-1:0] o_data_rdata,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output ByteMask               o_mem_be,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  MemArbState  state, stateNext;
  ByteMask     laneBe;
  logic [31:0] laneWdata;
  logic        laneMisaligned;
  logic        grantData, grantInst, forceInst;
  logic        unusedInstLo;

  mem_lane_gen uLaneGen (
    .access     (i_data_access),
    .addrLo     (i_data_addr[1:0]),
    .wdata      (i_data_wdata[31:0]),
    .byteMask   (laneBe),
    .wdataRep   (laneWdata),
    .misaligned (laneMisaligned)
  );

  // Fetches are always word-aligned; the low PC bits carry no information.
  assign unusedInstLo = ^i_inst_addr[1:0];

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int CNT_W = $clog2(MAX_DATA_BURST + 1);
  logic [CNT_W-1:0] burstCnt;

  assign forceInst = i_inst_req && (burstCnt == CNT_W'(MAX_DATA_BURST));

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      burstCnt <= '0;
    end else if (state == IDLE) begin
      if (grantInst || !i_inst_req) begin
        burstCnt <= '0;
      end else if (grantData && (burstCnt != CNT_W'(MAX_DATA_BURST))) begin
        burstCnt <= burstCnt + 1'b1;
      end
    end
  end
`else
  logic [31:0] unusedBurst;
  assign unusedBurst = 32'(MAX_DATA_BURST);
  assign forceInst   = 1'b0;
`endif

  assign grantData = (state == IDLE) && i_data_req && !forceInst;
  assign grantInst = (state == IDLE) && i_inst_req && !grantData;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (grantData) begin
          stateNext = laneMisaligned ? ERR : DATA;
        end else if (grantInst) begin
          stateNext = INST;
        end
      end
      INST, DATA: if (i_mem_ack) stateNext = IDLE;
      default:    stateNext = IDLE;
    endcase
  end

  // Transaction fields are captured once at grant and held until the next grant.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_mem_addr  <= '0;
      o_mem_we    <= 1'b0;
      o_mem_be    <= '0;
      o_mem_wdata <= '0;
    end else if (grantData && !laneMisaligned) begin
      o_mem_addr  <= {i_data_addr[ADDR_WIDTH-1:2], 2'b00};
      o_mem_we    <= i_data_we;
      o_mem_be    <= laneBe;
      o_mem_wdata <= laneWdata;
    end else if (grantInst) begin
      o_mem_addr  <= {i_inst_addr[ADDR_WIDTH-1:2], 2'b00};
      o_mem_we    <= 1'b0;
      o_mem_be    <= 4'b1111;
      o_mem_wdata <= '0;
    end
  end

  assign o_mem_req    = (state == INST) || (state == DATA);
  assign o_inst_ack   = (state == INST) && i_mem_ack;
  assign o_data_ack   = ((state == DATA) && i_mem_ack) || (state == ERR);
  assign o_data_err   = (state == ERR);
  assign o_inst_data  = o_inst_ack ? i_mem_rdata : '0;
  assign o_data_rdata = ((state == DATA) && i_mem_ack) ? i_mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table of data accesses plus
// hand-written sequences for arbitration, fairness, spurious ack and reset.
module tb_mem_port_arbiter;
  import CoreDefs::*;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_inst_req;
  logic [31:0] i_inst_addr;
  logic        o_inst_ack;
  logic [31:0] o_inst_data;
  logic        i_data_req;
  logic        i_data_we;
  logic [31:0] i_data_addr;
  DataAccess   i_data_access;
  logic [31:0] i_data_wdata;
  logic        o_data_ack;
  logic        o_data_err;
  logic [31:0] o_data_rdata;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  ByteMask     o_mem_be;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .i_clock       (clk),
    .i_reset       (i_reset),
    .i_inst_req    (i_inst_req),
    .i_inst_addr   (i_inst_addr),
    .o_inst_ack    (o_inst_ack),
    .o_inst_data   (o_inst_data),
    .i_data_req    (i_data_req),
    .i_data_we     (i_data_we),
    .i_data_addr   (i_data_addr),
    .i_data_access (i_data_access),
    .i_data_wdata  (i_data_wdata),
    .o_data_ack    (o_data_ack),
    .o_data_err    (o_data_err),
    .o_data_rdata  (o_data_rdata),
    .o_mem_req     (o_mem_req),
    .o_mem_we      (o_mem_we),
    .o_mem_addr    (o_mem_addr),
    .o_mem_be      (o_mem_be),
    .o_mem_wdata   (o_mem_wdata),
    .i_mem_ack     (i_mem_ack),
    .i_mem_rdata   (i_mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    DataAccess   acc;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] expAddr;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
    logic        expErr;
  } DataVec;

  DataVec vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Issues one data request, scrambles the requester after grant, and
  // answers with i_mem_ack in the lat-th cycle of the transaction.
  task automatic runData(input string tag, input DataVec v, input logic [31:0] rdata);
    @(negedge clk);
    i_data_req    = 1'b1;
    i_data_we     = v.we;
    i_data_addr   = v.addr;
    i_data_access = v.acc;
    i_data_wdata  = v.wdata;
    @(negedge clk);
    i_data_req    = 1'b0;
    i_data_we     = ~v.we;
    i_data_addr   = 32'hFFFF_FFFF;
    i_data_access = ACC_BYTE;
    i_data_wdata  = 32'h0;
    #1;
    if (v.expErr) begin
      check({tag, "_err_ack"}, o_data_ack, 1);
      check({tag, "_err_flag"}, o_data_err, 1);
      check({tag, "_err_noreq"}, o_mem_req, 0);
      @(negedge clk); #1;
      check({tag, "_err_once"}, o_data_ack, 0);
      check({tag, "_err_noreq2"}, o_mem_req, 0);
    end else begin
      check({tag, "_req"}, o_mem_req, 1);
      check({tag, "_addr"}, o_mem_addr, v.expAddr);
      check({tag, "_be"}, o_mem_be, v.expBe);
      check({tag, "_wdata"}, o_mem_wdata, v.expWdata);
      check({tag, "_we"}, o_mem_we, v.we);
      for (int c = 1; c < v.lat; c++) begin
        check({tag, "_early_ack"}, o_data_ack, 0);
        @(negedge clk); #1;
      end
      i_mem_ack   = 1'b1;
      i_mem_rdata = rdata;
      #1;
      check({tag, "_ack"}, o_data_ack, 1);
      check({tag, "_noerr"}, o_data_err, 0);
      check({tag, "_rdata"}, o_data_rdata, rdata);
      check({tag, "_addr_held"}, o_mem_addr, v.expAddr);
      @(negedge clk);
      i_mem_ack = 1'b0;
      #1;
      check({tag, "_ack_pulse"}, o_data_ack, 0);
      check({tag, "_req_drop"}, o_mem_req, 0);
    end
  endtask

  initial begin
    logic [6:0] order;
    logic [6:0] expOrder;
    int         nGrant;
    int         nData;
    DataVec     rv;

    vecs[0] = '{1'b1, 32'h104, ACC_WORD,  32'hDEADBEEF, 2, 32'h104, 4'b1111, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{1'b1, 32'h203, ACC_BYTE,  32'h000000A5, 1, 32'h200, 4'b1000, 32'hA5A5A5A5, 1'b0};
    vecs[2] = '{1'b1, 32'h202, ACC_HALF,  32'h00001234, 3, 32'h200, 4'b1100, 32'h12341234, 1'b0};
    vecs[3] = '{1'b0, 32'h101, ACC_BYTE,  32'h11223344, 1, 32'h100, 4'b0010, 32'h44444444, 1'b0};
    vecs[4] = '{1'b0, 32'h301, ACC_HALF,  32'h0,        1, 32'h0,   4'b0000, 32'h0,        1'b1};
    vecs[5] = '{1'b0, 32'h302, ACC_WORD,  32'h0,        1, 32'h0,   4'b0000, 32'h0,        1'b1};
    vecs[6] = '{1'b0, 32'h000, ACC_DWORD, 32'h0,        1, 32'h0,   4'b0000, 32'h0,        1'b1};
    vecs[7] = '{1'b0, 32'h400, ACC_WORD,  32'h0,        2, 32'h400, 4'b1111, 32'h0,        1'b0};

    i_reset = 1'b0; i_inst_req = 1'b0; i_inst_addr = '0;
    i_data_req = 1'b0; i_data_we = 1'b0; i_data_addr = '0;
    i_data_access = ACC_BYTE; i_data_wdata = '0;
    i_mem_ack = 1'b0; i_mem_rdata = '0;
    #2;
    check("rst_req", o_mem_req, 0);
    check("rst_addr", o_mem_addr, 0);
    check("rst_be", o_mem_be, 0);
    check("rst_wdata", o_mem_wdata, 0);
    check("rst_dack", o_data_ack, 0);
    check("rst_iack", o_inst_ack, 0);
    @(negedge clk);
    i_reset = 1'b1;

    for (int i = 0; i < 8; i++)
      runData($sformatf("v%0d", i), vecs[i], 32'hA000_0000 + 32'(i));

    // Simultaneous requests: data first, then the fetch.
    @(negedge clk);
    i_inst_req = 1'b1; i_inst_addr = 32'h43;
    i_data_req = 1'b1; i_data_we = 1'b0; i_data_addr = 32'h80; i_data_access = ACC_WORD;
    @(negedge clk); #1;
    check("sim_d_addr", o_mem_addr, 32'h80);
    check("sim_d_we", o_mem_we, 0);
    i_mem_ack = 1'b1; i_mem_rdata = 32'hCAFE0001; #1;
    check("sim_d_ack", o_data_ack, 1);
    check("sim_d_noiack", o_inst_ack, 0);
    check("sim_d_rdata", o_data_rdata, 32'hCAFE0001);
    @(negedge clk);
    i_mem_ack = 1'b0; i_data_req = 1'b0; #1;
    check("sim_idle", o_mem_req, 0);
    @(negedge clk); #1;
    check("sim_i_req", o_mem_req, 1);
    check("sim_i_addr", o_mem_addr, 32'h40);
    check("sim_i_be", o_mem_be, 4'b1111);
    check("sim_i_we", o_mem_we, 0);
    i_mem_ack = 1'b1; i_mem_rdata = 32'h00500093; #1;
    check("sim_i_ack", o_inst_ack, 1);
    check("sim_i_data", o_inst_data, 32'h00500093);
    check("sim_i_nodack", o_data_ack, 0);
    @(negedge clk);
    i_mem_ack = 1'b0; i_inst_req = 1'b0;

    // Spurious ack while idle.
    @(negedge clk);
    i_mem_ack = 1'b1; #1;
    check("spur_dack", o_data_ack, 0);
    check("spur_iack", o_inst_ack, 0);
    @(negedge clk); #1;
    check("spur_req", o_mem_req, 0);
    i_mem_ack = 1'b0;

    // Fetch held while six data requests stream back to back.
    @(negedge clk);
    i_inst_req = 1'b1; i_inst_addr = 32'h40;
    i_data_req = 1'b1; i_data_we = 1'b0; i_data_addr = 32'h80; i_data_access = ACC_WORD;
    order = 'x; nGrant = 0; nData = 0;
    for (int cyc = 0; cyc < 80 && nGrant < 7; cyc++) begin
      @(negedge clk);
      i_mem_ack = o_mem_req; i_mem_rdata = 32'h1;
      #1;
      if (o_data_ack) begin
        order[nGrant] = 1'b0; nGrant++; nData++;
        if (nData == 6) i_data_req = 1'b0;
      end else if (o_inst_ack) begin
        order[nGrant] = 1'b1; nGrant++;
        i_inst_req = 1'b0;
      end
    end
    @(negedge clk);
    i_mem_ack = 1'b0; i_data_req = 1'b0; i_inst_req = 1'b0;
`ifdef MEM_ARB_FAIRNESS_EN
    expOrder = 7'b0010000;
`else
    expOrder = 7'b1000000;
`endif
    check("fair_grants", 32'(nGrant), 7);
    for (int k = 0; k < 7; k++)
      check($sformatf("fair_order%0d", k), order[k], expOrder[k]);

    // Reset in the middle of a data transaction.
    @(negedge clk);
    i_data_req = 1'b1; i_data_we = 1'b1; i_data_addr = 32'h500;
    i_data_access = ACC_WORD; i_data_wdata = 32'h55;
    @(negedge clk); #1;
    check("rst_mid_req_before", o_mem_req, 1);
    i_reset = 1'b0; #1;
    check("rst_mid_req", o_mem_req, 0);
    check("rst_mid_addr", o_mem_addr, 0);
    i_mem_ack = 1'b1; #1;
    check("rst_mid_noack", o_data_ack, 0);
    @(negedge clk);
    i_mem_ack = 1'b0; i_data_req = 1'b0; i_reset = 1'b1;
    rv = '{1'b0, 32'h600, ACC_WORD, 32'h0, 1, 32'h600, 4'b1111, 32'h0, 1'b0};
    runData("post_rst", rv, 32'h600D600D);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
